// File: rtl/hazard_sched.sv
// Hazard and sequencing controller around the Exec stage: forwarding, stalls, flushes.
// Optional saturating stall/flush perf counters when HAZARD_PERF_EN is defined.
module hazard_sched #(
    parameter int MULTI_CYC = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       RA1E,
    input  logic [3:0]       RA2E,
    input  logic [3:0]       WriteAddrE,
    input  logic [3:0]       WriteAddrM,
    input  logic [3:0]       WriteAddrW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             BranchTakenE,
    input  logic             MultiStartE,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
`ifdef HAZARD_PERF_EN
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount,
`endif
    output logic             BusyE
);

    localparam int CW = (MULTI_CYC > 2) ? $clog2(MULTI_CYC) : 1;
    localparam bit MULTI_EN = (MULTI_CYC > 1);
    localparam logic [CW-1:0] CNT_LOAD =
        (MULTI_CYC > 1) ? CW'(MULTI_CYC - 2) : '0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          ld_stall;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;

    // Operand A select: Mem result beats Writeback result; R15 is the PC, never forwarded.
    always_comb begin
        fwd_a = 2'b00;
        if (RA1E != 4'hF) begin
            if (RegWriteM && (WriteAddrM == RA1E)) begin
                fwd_a = 2'b10;
            end else if (RegWriteW && (WriteAddrW == RA1E)) begin
                fwd_a = 2'b01;
            end
        end
    end

    // Operand B select, same priority as operand A.
    always_comb begin
        fwd_b = 2'b00;
        if (RA2E != 4'hF) begin
            if (RegWriteM && (WriteAddrM == RA2E)) begin
                fwd_b = 2'b10;
            end else if (RegWriteW && (WriteAddrW == RA2E)) begin
                fwd_b = 2'b01;
            end
        end
    end

    assign ld_stall = MemtoRegE && RegWriteE &&
                      ((RA1D == WriteAddrE) || (RA2D == WriteAddrE));

    // Multicycle FSM state and down-counter; reset aborts any op in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and stall/flush decode: multicycle hold > branch flush > load-use bubble.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        BusyE     = 1'b0;
        forwardAE = fwd_a;
        forwardBE = fwd_b;
        unique case (state_q)
            IDLE: begin
                if (BranchTakenE) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (MultiStartE && MULTI_EN) begin
                    StallF  = 1'b1;
                    StallD  = 1'b1;
                    StallE  = 1'b1;
                    BusyE   = 1'b1;
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end else if (ld_stall) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end
            BUSY: begin
                BusyE = 1'b1;
                if (cnt_q != '0) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    cnt_d  = cnt_q - CW'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (!reset) begin
            StallF    = 1'b0;
            StallD    = 1'b0;
            StallE    = 1'b0;
            BusyE     = 1'b0;
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            forwardAE = 2'b00;
            forwardBE = 2'b00;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Saturating counters of stalled-fetch cycles and Exec-bubble cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (StallF && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (FlushE && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
`endif

endmodule
